i2c_line_filter: RTL and testbench

- Input-side conditioning stage for the I2C pads.
- Synchronises and deglitches raw SDA/SCL, then produces filtered levels, single-cycle SCL edge strobes and START/STOP strobes.
- Tracks bus-busy state.
- Generates the delayed clock SCL_DLY, which the SDA output driver consumes to time its post-falling-edge hold window. It sits between the pad inputs and the slave protocol logic.

---
 rtl/i2c_pkg.sv | 15 +
 rtl/line_deglitch.sv | 52 +++++
 rtl/i2c_line_filter.sv | 125 ++++++++++++
 tb/tb_i2c_line_filter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus state encoding, idle line level and default
// filter/delay depths used by the line filter and the slave protocol block.
package i2c_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

    localparam logic IDLE_LEVEL   = 1'b1;
    localparam int   DEF_FILT_CYC = 4;
    localparam int   DEF_CNT_W    = 3;
    localparam int   DEF_DLY_CYC  = 8;

endpackage

// File: rtl/line_deglitch.sv
// One I2C line: two-flop synchroniser followed by a consecutive-sample
// counter filter. The filtered level only moves after FILT_CYC stable samples.
module line_deglitch
    import i2c_pkg::*;
#(
    parameter int FILT_CYC = DEF_FILT_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_filt
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;

    assign w_differs = (r_sync2 != r_filt);
    assign o_filt    = r_filt;

    // Two-flop synchroniser, reset to the idle (released) line level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= IDLE_LEVEL;
            r_sync2 <= IDLE_LEVEL;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: any return to the filtered level restarts the count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt <= IDLE_LEVEL;
            r_cnt  <= {CNT_W{1'b0}};
        end else if (w_differs) begin
            if (r_cnt == CNT_W'(FILT_CYC - 1)) begin
                r_filt <= r_sync2;
                r_cnt  <= {CNT_W{1'b0}};
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= {CNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/i2c_line_filter.sv
// I2C pad input conditioning: deglitched SDA/SCL, SCL edge strobes,
// START/STOP strobes, bus-busy tracking and the delayed SCL for the SDA driver.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILT_CYC = DEF_FILT_CYC,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DLY_CYC  = DEF_DLY_CYC
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sda_in,
    input  logic i_scl_in,
    output logic o_sda_filt,
    output logic o_scl_filt,
    output logic o_scl_dly,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_bus_busy
);

    logic               w_sda_filt;
    logic               w_scl_filt;
    logic               w_start_det;
    logic               w_stop_det;
    logic               w_scl_held_high;
    logic               r_sda_prev;
    logic               r_scl_prev;
    logic               r_scl_rise;
    logic               r_scl_fall;
    logic               r_start;
    logic               r_stop;
    logic               r_bus_busy;
    bus_state_t         r_state;
    logic [DLY_CYC-1:0] r_dly;

    line_deglitch #(.FILT_CYC(FILT_CYC), .CNT_W(CNT_W)) u_sda_deglitch (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_sda_in),
        .o_filt  (w_sda_filt)
    );

    line_deglitch #(.FILT_CYC(FILT_CYC), .CNT_W(CNT_W)) u_scl_deglitch (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_scl_in),
        .o_filt  (w_scl_filt)
    );

    // SCL must be high before and after, so a simultaneous SDA/SCL change never qualifies
    assign w_scl_held_high = r_scl_prev & w_scl_filt;
    assign w_start_det     = r_sda_prev & ~w_sda_filt & w_scl_held_high;
    assign w_stop_det      = ~r_sda_prev & w_sda_filt & w_scl_held_high;

    // Previous-cycle copies and registered edge / condition strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sda_prev <= IDLE_LEVEL;
            r_scl_prev <= IDLE_LEVEL;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_sda_prev <= w_sda_filt;
            r_scl_prev <= w_scl_filt;
            r_scl_rise <= ~r_scl_prev & w_scl_filt;
            r_scl_fall <= r_scl_prev & ~w_scl_filt;
            r_start    <= w_start_det;
            r_stop     <= w_stop_det;
        end
    end

    // Bus-busy FSM; repeated START keeps BUSY, stray STOP keeps IDLE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_bus_busy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_det) begin
                        r_state    <= BUSY;
                        r_bus_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_stop_det) begin
                        r_state    <= IDLE;
                        r_bus_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_bus_busy <= 1'b0;
                end
            endcase
        end
    end

    // SCL delay line feeding the SDA driver's hold-window timing
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dly <= {DLY_CYC{IDLE_LEVEL}};
        end else begin
            r_dly[0] <= w_scl_filt;
            for (int i = 1; i < DLY_CYC; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign o_sda_filt = w_sda_filt;
    assign o_scl_filt = w_scl_filt;
    assign o_scl_dly  = r_dly[DLY_CYC-1];
    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
    assign o_bus_busy = r_bus_busy;

endmodule

// File: tb/tb_i2c_line_filter.sv
// Directed bench for i2c_line_filter (FILT_CYC=4, DLY_CYC=8): vector table
// for the protocol sequence plus hand-written glitch, delay and reset cases.
module tb_i2c_line_filter;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic sda_in   = 1'b1;
    logic scl_in   = 1'b1;
    logic sda_filt, scl_filt, scl_dly, scl_rise, scl_fall, start, stop, bus_busy;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_line_filter #(.FILT_CYC(4), .CNT_W(3), .DLY_CYC(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sda_in   (sda_in),
        .i_scl_in   (scl_in),
        .o_sda_filt (sda_filt),
        .o_scl_filt (scl_filt),
        .o_scl_dly  (scl_dly),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (start),
        .o_stop     (stop),
        .o_bus_busy (bus_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sda;
        logic scl;
        int   n;
        logic e_sf;
        logic e_cf;
        logic e_rise;
        logic e_fall;
        logic e_start;
        logic e_stop;
        logic e_busy;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input logic sf, input logic cf, input logic rs,
                           input logic fl, input logic st, input logic sp, input logic bb);
        chk({tag, " sda_filt"}, sda_filt, sf);
        chk({tag, " scl_filt"}, scl_filt, cf);
        chk({tag, " scl_rise"}, scl_rise, rs);
        chk({tag, " scl_fall"}, scl_fall, fl);
        chk({tag, " start"},    start,    st);
        chk({tag, " stop"},     stop,     sp);
        chk({tag, " bus_busy"}, bus_busy, bb);
    endtask

    function automatic logic raw_scl(input int t);
        if (t < 0) return 1'b1;
        else return (((t / 20) % 2) == 0) ? 1'b0 : 1'b1;
    endfunction

    initial begin
        // sda, scl, cycles, then expected sda_f, scl_f, rise, fall, start, stop, busy
        tbl[0]  = '{1'b1, 1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        #12;
        chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset scl_dly", scl_dly, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 100; k++) begin
            step(1);
            chk($sformatf("idle%0d strobes", k), scl_rise | scl_fall | start | stop, 1'b0);
            chk($sformatf("idle%0d busy", k), bus_busy, 1'b0);
        end

        for (int k = 1; k <= 14; k++) begin
            scl_in = (k <= 3) ? 1'b0 : 1'b1;
            step(1);
            chk($sformatf("glitch3 k%0d scl_filt", k), scl_filt, 1'b1);
            chk($sformatf("glitch3 k%0d scl_fall", k), scl_fall, 1'b0);
        end

        for (int k = 1; k <= 16; k++) begin
            scl_in = (k <= 4) ? 1'b0 : 1'b1;
            step(1);
            chk($sformatf("pulse4 k%0d scl_filt", k), scl_filt, !(k >= 6 && k <= 9));
            chk($sformatf("pulse4 k%0d scl_fall", k), scl_fall, k == 7);
            chk($sformatf("pulse4 k%0d scl_rise", k), scl_rise, k == 11);
        end

        for (int i = 0; i < 16; i++) begin
            sda_in = tbl[i].sda;
            scl_in = tbl[i].scl;
            step(tbl[i].n);
            chk_all($sformatf("vec%0d", i), tbl[i].e_sf, tbl[i].e_cf, tbl[i].e_rise,
                    tbl[i].e_fall, tbl[i].e_start, tbl[i].e_stop, tbl[i].e_busy);
        end

        // Raw SCL square wave: filtered lags by 5 loop steps, delayed by 13
        for (int t = 0; t < 180; t++) begin
            scl_in = raw_scl(t);
            step(1);
            chk($sformatf("dly t%0d scl_filt", t), scl_filt, raw_scl(t - 5));
            chk($sformatf("dly t%0d scl_dly", t), scl_dly, raw_scl(t - 13));
            chk($sformatf("dly t%0d start/stop", t), start | stop, 1'b0);
        end
        scl_in = 1'b1;
        step(16);

        sda_in = 1'b0;
        step(7);
        chk("pre-reset start", start, 1'b1);
        chk("pre-reset busy", bus_busy, 1'b1);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", bus_busy, 1'b0);
        chk("midreset sda_filt", sda_filt, 1'b1);
        chk("midreset stop", stop, 1'b0);
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk($sformatf("release k%0d stop", k), stop, 1'b0);
            chk($sformatf("release k%0d start", k), start, k == 7);
            chk($sformatf("release k%0d busy", k), bus_busy, k >= 7);
            chk($sformatf("release k%0d sda_filt", k), sda_filt, !(k >= 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
